// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared states and sizing helper for the serial binary-to-BCD converter
package bcd_pkg;

    typedef enum logic [1:0] {
        OCIOSO,
        CONVERTE,
        FIM
    } estado_bcd_t;

    // Decimal digits required to display the largest n_bits unsigned value.
    function automatic int digitos_necessarios(input int n_bits);
        longint maximo;
        longint potencia;
        int     digitos;
        maximo   = (longint'(1) << n_bits) - 1;
        potencia = 10;
        digitos  = 1;
        while (potencia <= maximo) begin
            potencia = potencia * 10;
            digitos  = digitos + 1;
        end
        return digitos;
    endfunction

endpackage

// File: rtl/corrige_digito_bcd.sv
// rtl/corrige_digito_bcd.sv - double-dabble digit correction: add 3 when the digit is 5 or more
module corrige_digito_bcd (
    input  logic [3:0] digito,
    output logic [3:0] corrigido
);

    assign corrigido = (digito >= 4'd5) ? (digito + 4'd3) : digito;

endmodule

// File: rtl/bin_para_bcd_serial.sv
// rtl/bin_para_bcd_serial.sv - iterative binary-to-BCD converter, one bit per clock; optional BCD_SINAL_EN for two's-complement input
module bin_para_bcd_serial
    import bcd_pkg::*;
#(
    parameter int N_BITS    = 8,
    parameter int N_DIGITOS = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [N_BITS-1:0]      bin_in,
    output logic                   busy,
    output logic                   valido,
    output logic [4*N_DIGITOS-1:0] bcd_out
`ifdef BCD_SINAL_EN
    ,
    output logic                   sinal_out
`endif
);

    localparam int              BW        = 4 * N_DIGITOS;
    localparam int              CW        = $clog2(N_BITS + 1);
    localparam logic [CW-1:0]   PENULTIMO = CW'(N_BITS - 1);

    generate
        if (N_BITS < 4) begin : g_erro_largura
            $error("bin_para_bcd_serial: N_BITS must be at least 4");
        end
        if (N_DIGITOS < digitos_necessarios(N_BITS)) begin : g_erro_digitos
            $error("bin_para_bcd_serial: N_DIGITOS too small for N_BITS");
        end
    endgenerate

    estado_bcd_t          estado;
    estado_bcd_t          prox_estado;
    logic [CW-1:0]        contador;
    logic [N_BITS-1:0]    bin_sr;
    logic [BW-1:0]        acc;
    logic [BW-1:0]        acc_corr;
    logic [BW+N_BITS-1:0] deslocado;
    logic [N_BITS-1:0]    captura;

`ifdef BCD_SINAL_EN
    logic sinal_cap;
    // Unary minus also maps the most negative value onto its unsigned magnitude.
    assign captura = bin_in[N_BITS-1] ? -bin_in : bin_in;
`else
    assign captura = bin_in;
`endif

    for (genvar i = 0; i < N_DIGITOS; i++) begin : g_corr
        corrige_digito_bcd u_corr (
            .digito    (acc[4*i +: 4]),
            .corrigido (acc_corr[4*i +: 4])
        );
    end

    assign deslocado = {acc_corr, bin_sr} << 1;
    assign busy      = (estado != OCIOSO);

    always_comb begin
        prox_estado = estado;
        case (estado)
            OCIOSO:   if (start) prox_estado = CONVERTE;
            CONVERTE: if (contador == PENULTIMO) prox_estado = FIM;
            FIM:      prox_estado = OCIOSO;
            default:  prox_estado = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado    <= OCIOSO;
            contador  <= '0;
            bin_sr    <= '0;
            acc       <= '0;
            bcd_out   <= '0;
            valido    <= 1'b0;
`ifdef BCD_SINAL_EN
            sinal_cap <= 1'b0;
            sinal_out <= 1'b0;
`endif
        end else begin
            estado <= prox_estado;
            valido <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (start) begin
                        bin_sr    <= captura;
                        acc       <= '0;
                        contador  <= '0;
`ifdef BCD_SINAL_EN
                        sinal_cap <= bin_in[N_BITS-1];
`endif
                    end
                end
                CONVERTE: begin
                    acc      <= deslocado[BW+N_BITS-1:N_BITS];
                    bin_sr   <= deslocado[N_BITS-1:0];
                    contador <= contador + CW'(1);
                end
                FIM: begin
                    bcd_out   <= acc;
                    valido    <= 1'b1;
`ifdef BCD_SINAL_EN
                    sinal_out <= sinal_cap;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_para_bcd_serial.sv
// tb/tb_bin_para_bcd_serial.sv - scoreboard bench for bin_para_bcd_serial (8-bit and 12-bit instances)
module tb_bin_para_bcd_serial;

    localparam int NB   = 8;
    localparam int ND   = 3;
    localparam int NB12 = 12;
    localparam int ND12 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              start, busy, valido;
    logic [NB-1:0]     bin_in;
    logic [4*ND-1:0]   bcd_out;
    logic              start12, busy12, valido12;
    logic [NB12-1:0]   bin_in12;
    logic [4*ND12-1:0] bcd_out12;
`ifdef BCD_SINAL_EN
    logic              sinal_out, sinal_out12;
`endif

    bin_para_bcd_serial #(.N_BITS(NB), .N_DIGITOS(ND)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .valido  (valido),
        .bcd_out (bcd_out)
`ifdef BCD_SINAL_EN
        ,
        .sinal_out (sinal_out)
`endif
    );

    bin_para_bcd_serial #(.N_BITS(NB12), .N_DIGITOS(ND12)) u_dut12 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start12),
        .bin_in  (bin_in12),
        .busy    (busy12),
        .valido  (valido12),
        .bcd_out (bcd_out12)
`ifdef BCD_SINAL_EN
        ,
        .sinal_out (sinal_out12)
`endif
    );

    typedef struct packed {
        logic [15:0] bcd;
        logic        sinal;
    } esperado_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    esperado_t   fila[$];
    esperado_t   e;
    logic [15:0] ultimo_bcd = '0;
    logic        valido_ant = 1'b0;

    // Reference: decimal digits by repeated division of the magnitude.
    function automatic esperado_t modelo(input longint v, input int nbits, input int ndig);
        esperado_t r;
        longint    mag;
        mag     = v;
        r.sinal = 1'b0;
`ifdef BCD_SINAL_EN
        if (v >= (longint'(1) << (nbits - 1))) begin
            mag     = (longint'(1) << nbits) - v;
            r.sinal = 1'b1;
        end
`endif
        r.bcd = '0;
        for (int d = 0; d < ndig; d++) begin
            r.bcd[4*d +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
        return r;
    endfunction

    task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp_v);
        n_tests++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, got, exp_v, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            ultimo_bcd = '0;
            valido_ant = 1'b0;
        end else if (valido) begin
            check("valido_pulse_width", 32'(valido_ant), 32'd0);
            if (fila.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valido: got bcd %0h with empty scoreboard at %0t", bcd_out, $time);
            end else begin
                e = fila.pop_front();
                ultimo_bcd = e.bcd;
                check("bcd_out", 32'(bcd_out), 32'(e.bcd[4*ND-1:0]));
`ifdef BCD_SINAL_EN
                check("sinal_out", 32'(sinal_out), 32'(e.sinal));
`endif
            end
            valido_ant = 1'b1;
        end else begin
            check("bcd_out_stable", 32'(bcd_out), 32'(ultimo_bcd[4*ND-1:0]));
            valido_ant = 1'b0;
        end
    end

    task automatic pulso(input logic [NB-1:0] v, input bit esperar);
        start  = 1'b1;
        bin_in = v;
        if (esperar) fila.push_back(modelo(longint'(v), NB, ND));
        @(posedge clk); #1;
        start  = 1'b0;
        bin_in = NB'($urandom);
    endtask

    task automatic aguarda();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("busy_timeout", 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        esperado_t e12;
        logic [NB12-1:0] v12;

        rst_n = 1'b0; start = 1'b0; bin_in = '0; start12 = 1'b0; bin_in12 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valido", 32'(valido), 32'd0);
        check("reset_bcd_out", 32'(bcd_out), 32'd0);
        check("reset_busy12", 32'(busy12), 32'd0);
        check("reset_bcd_out12", 32'(bcd_out12), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // T1: zero input, busy spans exactly N_BITS+1 cycles
        pulso('0, 1'b1);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        check("t1_busy_cycles", 32'(n), 32'd9);
        check("t1_valido_after_busy", 32'(valido), 32'd1);
        @(posedge clk); #1;

        // T2: edge values then exhaustive sweep
        pulso(8'd255, 1'b1); aguarda();
        pulso(8'd99, 1'b1);  aguarda();
        for (int v = 0; v < 256; v++) begin
            pulso(NB'(v), 1'b1);
            aguarda();
        end

        // T3: start during a conversion is ignored
        pulso(8'd42, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        start = 1'b1; bin_in = 8'd200;
        @(posedge clk); #1;
        start = 1'b0;
        aguarda();
        repeat (15) begin @(posedge clk); #1; end
        check("t3_scoreboard_empty", 32'(fila.size()), 32'd0);

        // T4: reset mid-conversion aborts without valido
        pulso(8'd77, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_valido", 32'(valido), 32'd0);
        check("t4_bcd_out", 32'(bcd_out), 32'd0);
        rst_n = 1'b1;
        repeat (15) begin @(posedge clk); #1; end
        pulso(8'd123, 1'b1);
        aguarda();

        // Random: junk starts while busy, chained starts on the valido cycle
        for (int it = 0; it < 300; it++) begin
            pulso(NB'($urandom), 1'b1);
            for (int c = 0; c < 9; c++) begin
                start  = ($urandom_range(0, 3) == 0);
                bin_in = NB'($urandom);
                @(posedge clk); #1;
            end
            start = 1'b0;
            if ($urandom_range(0, 1) == 0) begin
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
        end
        aguarda();
        repeat (12) begin @(posedge clk); #1; end
        check("random_scoreboard_empty", 32'(fila.size()), 32'd0);

        // T5: 12-bit instance, latency and back-to-back start
        start12 = 1'b1; bin_in12 = 12'd4095;
        @(posedge clk); #1;
        start12 = 1'b0; bin_in12 = NB12'($urandom);
        n = 0;
        while (!valido12 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        e12 = modelo(64'd4095, NB12, ND12);
        check("t5_latency", 32'(n), 32'd13);
        check("t5_bcd_4095", 32'(bcd_out12), 32'(e12.bcd));
        v12 = NB12'($urandom);
        start12 = 1'b1; bin_in12 = v12;
        @(posedge clk); #1;
        start12 = 1'b0; bin_in12 = NB12'($urandom);
        check("t5_accepted_on_valido", 32'(busy12), 32'd1);
        check("t5_bcd_held", 32'(bcd_out12), 32'(e12.bcd));
        n = 0;
        while (!valido12 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        e12 = modelo(longint'(v12), NB12, ND12);
        check("t5_latency_b2b", 32'(n), 32'd13);
        check("t5_bcd_b2b", 32'(bcd_out12), 32'(e12.bcd));
`ifdef BCD_SINAL_EN
        check("t5_sinal_b2b", 32'(sinal_out12), 32'(e12.sinal));
`endif
        repeat (3) begin @(posedge clk); #1; end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
